// File: rtl/sync_stream_packer_pkg.sv
// rtl/sync_stream_packer_pkg.sv - shared constants and lane helper for the stream packer
package sync_stream_packer_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_PACK_RATIO = 4;

   // Bit offset of a lane inside the packed word; lane 0 sits at the LSBs.
   function automatic int lane_base(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/sync_stream_packer.sv
// rtl/sync_stream_packer.sv - packs PACK_RATIO narrow beats into one wide word with flush and clear
module sync_stream_packer
   import sync_stream_packer_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int PACK_RATIO    = DEFAULT_PACK_RATIO,
   parameter int LB_PACK_RATIO = $clog2(PACK_RATIO)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_WIDTH-1:0]            in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             flush,
   input  logic                             clear,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
   output logic [PACK_RATIO-1:0]            out_keep,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [LB_PACK_RATIO:0]           count
);

   localparam int                WORD_W   = DATA_WIDTH * PACK_RATIO;
   localparam int                CNT_W    = LB_PACK_RATIO + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(PACK_RATIO);

   logic [WORD_W-1:0]     acc_word;
   logic [CNT_W-1:0]      acc_cnt;
   logic                  flush_pend;

   logic                  accept;
   logic [CNT_W-1:0]      cnt_n;
   logic [WORD_W-1:0]     acc_n;
   logic                  word_full;
   logic                  want_partial;
   logic                  out_free;
   logic                  load;
   logic [WORD_W-1:0]     load_data;
   logic [PACK_RATIO-1:0] load_keep;

   // in_ready depends only on held state, never on out_ready or in_valid.
   assign in_ready = (acc_cnt != FULL_CNT) && !flush_pend;
   assign count    = acc_cnt;

   // Fold this cycle's beat into the accumulator, then decide whether a word leaves it.
   always_comb begin
      accept       = in_valid && in_ready;
      cnt_n        = acc_cnt + (accept ? CNT_W'(1) : CNT_W'(0));
      acc_n        = acc_word;
      load_data    = '0;
      load_keep    = '0;
      for (int k = 0; k < PACK_RATIO; k++) begin
         if (accept && (acc_cnt == CNT_W'(k))) begin
            acc_n[lane_base(k, DATA_WIDTH) +: DATA_WIDTH] = in_data;
         end
      end
      // Flush sees the post-beat count, so a same-cycle beat is included.
      word_full    = (cnt_n == FULL_CNT);
      want_partial = (flush || flush_pend) && (cnt_n != '0) && !word_full;
      out_free     = !out_valid || out_ready;
      load         = out_free && (word_full || want_partial);
      // Only filled lanes are copied; stale lanes from earlier words read as zero.
      for (int k = 0; k < PACK_RATIO; k++) begin
         if (CNT_W'(k) < cnt_n) begin
            load_data[lane_base(k, DATA_WIDTH) +: DATA_WIDTH] =
               acc_n[lane_base(k, DATA_WIDTH) +: DATA_WIDTH];
            load_keep[k] = 1'b1;
         end
      end
   end

   // Accumulator and output register; clear behaves exactly like reset and wins over everything.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc_word   <= '0;
         acc_cnt    <= '0;
         flush_pend <= 1'b0;
         out_data   <= '0;
         out_keep   <= '0;
         out_valid  <= 1'b0;
      end else begin
         acc_word <= acc_n;
         if (load) begin
            out_data   <= load_data;
            out_keep   <= load_keep;
            out_valid  <= 1'b1;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
         end else begin
            acc_cnt    <= cnt_n;
            flush_pend <= want_partial;
            if (out_valid && out_ready) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/sync_stream_packer.md
Name: sync_stream_packer

Overview:
- Downstream stage of sync_2t_fifo: consumes its out_data/out_valid/out_ready stream and packs PACK_RATIO narrow beats into one wide word for a wider consumer.
- Supports a flush for partial words (per-lane keep mask) and a synchronous clear matching the FIFO's clear semantics.
- Beat order is little-endian: first accepted beat lands in lane 0, i.e. the LSBs.

Parameters:
- DATA_WIDTH, 8, width of one input beat in bits.
- PACK_RATIO, 4, beats per output word; must be a power of two and at least 2.
- LB_PACK_RATIO, $clog2(PACK_RATIO), derived; do not override.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-high.
- in_data  in  DATA_WIDTH  input beat (from the FIFO's out_data).
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer can accept a beat.
- flush  in  1  single-cycle request to emit the current partial word.
- clear  in  1  synchronous discard of all held data.
- out_data  out  DATA_WIDTH*PACK_RATIO  packed word; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_keep  out  PACK_RATIO  lane-valid mask for out_data.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- count  out  LB_PACK_RATIO+1  number of beats currently held in the accumulator.

Behaviour:
- Storage is an accumulator (PACK_RATIO lanes, acc_cnt 0..PACK_RATIO) plus one output register (out_data, out_keep, out_valid).
- The output register is "free" in a cycle when out_valid==0 or out_ready==1.
- A handshake occurs when valid && ready on a posedge. in_ready is registered-state only and has no combinational path from out_ready or in_valid.
- Reset (rst=1 at posedge) drives:
  - out_valid=0, out_data=0, out_keep=0
  - acc_cnt=0, flush_pend=0
  - in_ready=1, count=0
- in_ready = (acc_cnt != PACK_RATIO) && !flush_pend.
- Accepted beat with acc_cnt < PACK_RATIO-1: written to lane acc_cnt; acc_cnt increments.
- Accepted beat with acc_cnt == PACK_RATIO-1 (completing beat):
  - Output register free: load the full word, out_keep=all ones, out_valid=1 on the same edge, acc_cnt=0. Latency from completing beat to out_valid is 1 cycle.
  - Output register not free: acc_cnt=PACK_RATIO (full), in_ready=0. On the first edge where the output register is free, the accumulator moves to the output register and acc_cnt=0.
- Flush is evaluated after any beat accepted in the same cycle, so that beat is included.
  - Resulting acc_cnt==0: flush is ignored, nothing is emitted.
  - Resulting acc_cnt==PACK_RATIO: treated as a normal full word.
  - Otherwise: set flush_pend; in_ready=0 while it is set.
- While flush_pend is set, on the first edge the output register is free:
  - out_data takes the filled lanes; unfilled lanes are 0.
  - out_keep has bits [acc_cnt-1:0] set.
  - out_valid=1; acc_cnt=0; flush_pend=0.
  - This may happen on the same edge the flush is sampled if the output register is already free.
- Output drain: on out_valid && out_ready with no new load that edge, out_valid=0. out_data/out_keep hold stable while out_valid && !out_ready.
- Clear: on the edge where clear=1 and rst=0, results are identical to reset. clear overrides any concurrent beat, flush or drain; a beat presented in that cycle is dropped.
- Width rules: acc_cnt and count are LB_PACK_RATIO+1 bits, so the value PACK_RATIO is representable. There is no wrap; acc_cnt never exceeds PACK_RATIO.
- count = acc_cnt at all times; it excludes the word in the output register.

Decomposition:
- Package sync_stream_packer_pkg holds a lane-index helper function and the default DATA_WIDTH/PACK_RATIO constants.
- Packer state is held in the accumulator and registers directly, with no separate state-machine encoding.
- No sub-module; the block is a single module.

Test Plan:
- Reset/clear: hold rst 10 cycles, release -> in_ready=1, out_valid=0, count=0, out_keep=0. Load 2 beats, pulse clear -> count=0, out_valid stays 0.
- Full pack, out_ready=1: push 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after 0x44, out_valid=1, out_data=0x44332211, out_keep=4'b1111, count=0. No bubble on in_ready throughout.
- Backpressure, out_ready=0: push 8 beats 0x01..0x08 -> first word held at 0x04030201, accumulator reaches count=4, in_ready=0. Raise out_ready -> words 0x04030201 then 0x08070605, in order, none lost.
- Flush partial: push 0xAA,0xBB, then pulse flush with in_valid=0 -> out_data=0x0000BBAA, out_keep=4'b0011, count=0. Flush with count=0 -> no output.
- Flush with a same-cycle beat: push 0xC1, then 0xC2 together with flush -> out_data=0x0000C2C1, out_keep=4'b0011.
- Back-to-back with sync_2t_fifo (DATA_WIDTH=8, depth 16): fill the FIFO with 16 random bytes, connect its output to the packer with out_ready=1 -> 4 words whose lanes match the scoreboard queue in order.
